// File: rtl/output_port_bank_if.sv
// Processor data-bus view of the output port bank: write/read strobes,
// byte address and write data from the bus master; registered readback
// data and its one-cycle qualifier from the bank.
//   we, re    : write / read strobes, sampled each rising edge
//   address   : byte address (ADDR_W bits)
//   data_in   : write data (DATA_W bits)
//   data_out  : registered readback data
//   rd_valid  : one-cycle strobe qualifying data_out
interface output_port_bank_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
);
  logic              we;
  logic              re;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;
  logic              rd_valid;

  modport master (output we, re, address, data_in, input data_out, rd_valid);
  modport slave  (input we, re, address, data_in, output data_out, rd_valid);
endinterface

// File: rtl/output_port_bank.sv
// Memory-mapped bank of up to eight output ports in a 32-byte window.
// Offset bits [4:3] pick overwrite/set/clear/toggle, bits [2:0] pick the port.
// Ports selected by PULSE_MASK auto-clear PULSE_LEN cycles after the last write.
//   clk, reset   : clock, synchronous active-high reset
//   bus          : processor bus (slave side)
//   port_out     : flat port values, port i at [i*DATA_W +: DATA_W]
//   port_changed : one-cycle strobe per port when its value changed
module output_port_bank #(
  parameter int unsigned       NUM_PORTS  = 4,
  parameter int unsigned       DATA_W     = 8,
  parameter int unsigned       ADDR_W     = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = ADDR_W'(8'hE0),
  parameter logic [7:0]        PULSE_MASK = 8'h00,
  parameter int unsigned       PULSE_LEN  = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  output_port_bank_if.slave           bus,
  output logic [NUM_PORTS*DATA_W-1:0] port_out,
  output logic [NUM_PORTS-1:0]        port_changed
);

  localparam int unsigned CNT_W = $clog2(PULSE_LEN + 1);

  logic [DATA_W-1:0]    port_q [NUM_PORTS];
  logic [DATA_W-1:0]    port_d [NUM_PORTS];
  logic [CNT_W-1:0]     cnt_q  [NUM_PORTS];
  logic [CNT_W-1:0]     cnt_d  [NUM_PORTS];
  logic [DATA_W-1:0]    wr_val [NUM_PORTS];
  logic [NUM_PORTS-1:0] hit;
  logic [NUM_PORTS-1:0] changed_q, changed_d;
  logic [DATA_W-1:0]    data_out_q, data_out_d;
  logic                 rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0]    rd_val;
  logic                 in_win;
  logic [1:0]           op;
  logic [2:0]           idx;

  // Window is 32-aligned, so the low five address bits are the offset.
  assign in_win = (bus.address[ADDR_W-1:5] == BASE_ADDR[ADDR_W-1:5]);
  assign op     = bus.address[4:3];
  assign idx    = bus.address[2:0];

  // Readback mux: unimplemented indices and out-of-window reads give 0.
  always_comb begin
    rd_val = '0;
    for (int i = 0; i < int'(NUM_PORTS); i++) begin
      if (in_win && idx == 3'(i)) rd_val = port_q[i];
    end
    rd_valid_d = bus.re;
    data_out_d = bus.re ? rd_val : data_out_q;
  end

  // Per-port write value for the decoded operation.
  always_comb begin
    for (int i = 0; i < int'(NUM_PORTS); i++) begin
      hit[i] = bus.we && in_win && (idx == 3'(i));
      case (op)
        2'd0:    wr_val[i] = bus.data_in;
        2'd1:    wr_val[i] = port_q[i] | bus.data_in;
        2'd2:    wr_val[i] = port_q[i] & ~bus.data_in;
        default: wr_val[i] = port_q[i] ^ bus.data_in;
      endcase
    end
  end

  // Port next state: a write beats expiry; counters only ever load on pulse ports.
  always_comb begin
    for (int i = 0; i < int'(NUM_PORTS); i++) begin
      port_d[i] = port_q[i];
      cnt_d[i]  = cnt_q[i];
      if (hit[i]) begin
        port_d[i] = wr_val[i];
        cnt_d[i]  = (PULSE_MASK[i] && (wr_val[i] != '0)) ? CNT_W'(PULSE_LEN) : '0;
      end else if (cnt_q[i] == CNT_W'(1)) begin
        port_d[i] = '0;
        cnt_d[i]  = '0;
      end else if (cnt_q[i] != '0) begin
        cnt_d[i]  = cnt_q[i] - CNT_W'(1);
      end
      changed_d[i] = (port_d[i] != port_q[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(NUM_PORTS); i++) begin
        port_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
      changed_q  <= '0;
      data_out_q <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      for (int i = 0; i < int'(NUM_PORTS); i++) begin
        port_q[i] <= port_d[i];
        cnt_q[i]  <= cnt_d[i];
      end
      changed_q  <= changed_d;
      data_out_q <= data_out_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  for (genvar g = 0; g < int'(NUM_PORTS); g++) begin : g_flat
    assign port_out[g*DATA_W +: DATA_W] = port_q[g];
  end

  assign port_changed = changed_q;
  assign bus.data_out = data_out_q;
  assign bus.rd_valid = rd_valid_q;

endmodule

// File: tb/tb_output_port_bank.sv
// Self-checking bench for output_port_bank: ports 0 and 2 in pulse mode
// (PULSE_LEN=4), ports 1 and 3 static; directed scenarios then random traffic.
module tb_output_port_bank;
  localparam int unsigned NP = 4;
  localparam int unsigned DW = 8;
  localparam int unsigned AW = 8;
  localparam int          PL = 4;
  localparam logic [7:0]  PM = 8'h05;

  logic clk;
  logic reset;
  logic [NP*DW-1:0] port_out;
  logic [NP-1:0]    port_changed;

  output_port_bank_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  output_port_bank #(
    .NUM_PORTS(NP), .DATA_W(DW), .ADDR_W(AW), .BASE_ADDR(8'hE0),
    .PULSE_MASK(PM), .PULSE_LEN(PL)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .port_out(port_out), .port_changed(port_changed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference: port values plus an absolute expiry edge number per port (0 = none).
  logic [7:0]    m_port [NP];
  int            m_dl   [NP];
  logic [7:0]    m_dout;
  logic          m_rv;
  logic [NP-1:0] m_chg;
  int            n = 0;
  bit            chk_en = 0;
  bit            win;
  int            off, op, idx;
  logic [7:0]    old_v, nv;

  initial begin
    for (int i = 0; i < int'(NP); i++) begin
      m_port[i] = '0;
      m_dl[i]   = 0;
    end
    m_dout = '0;
    m_rv   = 1'b0;
    m_chg  = '0;
  end

  always @(posedge clk) begin
    n++;
    if (reset) begin
      for (int i = 0; i < int'(NP); i++) begin
        m_port[i] = '0;
        m_dl[i]   = 0;
      end
      m_dout = '0;
      m_rv   = 1'b0;
      m_chg  = '0;
      chk_en = 1;
    end else begin
      win = (bus.address >= 8'hE0);
      off = int'(bus.address) - 224;
      op  = off / 8;
      idx = off % 8;
      if (bus.re) begin
        m_rv   = 1'b1;
        m_dout = (win && idx < int'(NP)) ? m_port[idx] : 8'h00;
      end else begin
        m_rv = 1'b0;
      end
      for (int i = 0; i < int'(NP); i++) begin
        old_v = m_port[i];
        nv    = old_v;
        if (bus.we && win && idx == i) begin
          case (op)
            0:       nv = bus.data_in;
            1:       nv = old_v | bus.data_in;
            2:       nv = old_v & ~bus.data_in;
            default: nv = old_v ^ bus.data_in;
          endcase
          m_dl[i] = (PM[i] && nv != 8'h00) ? n + PL : 0;
        end else if (m_dl[i] != 0 && m_dl[i] == n) begin
          nv      = 8'h00;
          m_dl[i] = 0;
        end
        m_port[i] = nv;
        m_chg[i]  = (nv != old_v);
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at t=%0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // Per-cycle comparison of every DUT output against the reference.
  always @(negedge clk) begin
    if (chk_en) begin
      check("data_out", 32'(bus.data_out), 32'(m_dout));
      check("rd_valid", 32'(bus.rd_valid), 32'(m_rv));
      for (int i = 0; i < int'(NP); i++)
        check($sformatf("port_out[%0d]", i), 32'(port_out[i*DW +: DW]), 32'(m_port[i]));
      check("port_changed", 32'(port_changed), 32'(m_chg));
    end
  end

  // One bus cycle: drive, let one rising edge pass, return at the falling edge.
  task automatic step(input logic rs, input logic w, input logic r,
                      input logic [7:0] a, input logic [7:0] d);
    reset       = rs;
    bus.we      = w;
    bus.re      = r;
    bus.address = a;
    bus.data_in = d;
    @(negedge clk);
    reset  = 1'b0;
    bus.we = 1'b0;
    bus.re = 1'b0;
  endtask

  task automatic idle(input int cycles);
    for (int c = 0; c < cycles; c++) step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
  endtask

  initial begin
    reset = 1'b1; bus.we = 1'b0; bus.re = 1'b0; bus.address = '0; bus.data_in = '0;
    step(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    step(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    idle(1);
    check("pin_reset_ports", {m_port[3], m_port[2], m_port[1], m_port[0]}, 32'h0);

    for (int a = 224; a < 228; a++) begin
      step(1'b0, 1'b0, 1'b1, 8'(a), 8'h00);
      check("pin_reset_read", 32'(m_dout), 32'h00);
      check("pin_reset_rv", 32'(m_rv), 32'h1);
    end

    step(1'b0, 1'b1, 1'b0, 8'hE1, 8'hA5);
    check("pin_p1_write", 32'(m_port[1]), 32'hA5);
    check("pin_p1_chg", 32'(m_chg), 32'h2);
    step(1'b0, 1'b1, 1'b0, 8'hE9, 8'h0A);
    check("pin_p1_set", 32'(m_port[1]), 32'hAF);
    step(1'b0, 1'b1, 1'b0, 8'hF1, 8'h81);
    check("pin_p1_clear", 32'(m_port[1]), 32'h2E);
    step(1'b0, 1'b1, 1'b0, 8'hF9, 8'hFF);
    check("pin_p1_toggle", 32'(m_port[1]), 32'hD1);
    check("pin_p1_toggle_chg", 32'(m_chg), 32'h2);
    step(1'b0, 1'b1, 1'b0, 8'hE9, 8'h01);
    check("pin_p1_nochange", 32'(m_port[1]), 32'hD1);
    check("pin_p1_nostrobe", 32'(m_chg), 32'h0);

    step(1'b0, 1'b1, 1'b0, 8'hE5, 8'h55);
    check("pin_oor_write", 32'(m_chg), 32'h0);
    step(1'b0, 1'b0, 1'b1, 8'hE5, 8'h00);
    check("pin_oor_read_idx", 32'(m_dout), 32'h00);
    step(1'b0, 1'b0, 1'b1, 8'h40, 8'h00);
    check("pin_oor_read_win", 32'(m_dout), 32'h00);
    check("pin_oor_read_rv", 32'(m_rv), 32'h1);

    step(1'b0, 1'b1, 1'b0, 8'hE0, 8'h11);
    step(1'b0, 1'b1, 1'b1, 8'hE0, 8'h22);
    check("pin_rw_same_read", 32'(m_dout), 32'h11);
    check("pin_rw_same_port", 32'(m_port[0]), 32'h22);
    idle(6);
    check("pin_rw_expired", 32'(m_port[0]), 32'h00);

    // Pulse: nonzero through edge k+3, clears at edge k+4.
    step(1'b0, 1'b1, 1'b0, 8'hE0, 8'h80);
    check("pin_pulse_set", 32'(m_port[0]), 32'h80);
    idle(3);
    check("pin_pulse_hold", 32'(m_port[0]), 32'h80);
    idle(1);
    check("pin_pulse_clear", 32'(m_port[0]), 32'h00);
    check("pin_pulse_clear_chg", 32'(m_chg), 32'h1);

    // Rewrite at k+2 moves the clear to k+6.
    step(1'b0, 1'b1, 1'b0, 8'hE0, 8'h80);
    idle(1);
    step(1'b0, 1'b1, 1'b0, 8'hE0, 8'h80);
    check("pin_rewrite_nostrobe", 32'(m_chg), 32'h0);
    idle(3);
    check("pin_rewrite_hold", 32'(m_port[0]), 32'h80);
    idle(1);
    check("pin_rewrite_clear", 32'(m_port[0]), 32'h00);

    // Reset mid-pulse: no strobe, stays zero afterwards.
    step(1'b0, 1'b1, 1'b0, 8'hE0, 8'h80);
    step(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    check("pin_rst_pulse_port", 32'(m_port[0]), 32'h00);
    check("pin_rst_pulse_chg", 32'(m_chg), 32'h0);
    idle(6);
    check("pin_rst_pulse_after", 32'(m_port[0]), 32'h00);

    for (int t = 0; t < 3000; t++) begin
      logic       rs, w, r;
      logic [7:0] a, d;
      rs = ($urandom_range(0, 99) == 0);
      w  = 1'($urandom_range(0, 1));
      r  = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) != 0) a = 8'hE0 | 8'($urandom_range(0, 31));
      else                           a = 8'($urandom_range(0, 255));
      d  = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
      step(rs, w, r, a, d);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 5));
    end

    idle(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/output_port_bank.md
# output_port_bank

Parametrised memory-mapped output port bank on the processor data bus: the next generation of the two-port E0/E1 output latch. It decodes a 32-byte address window into up to eight output ports. Each port supports overwrite, bit-set, bit-clear and bit-toggle writes, and the bus can read any port back. Ports selected by a mask run in pulse mode, where they auto-clear a fixed number of cycles after the last write.

## Interface
- NUM_PORTS, 4, number of implemented ports (1..8)
- DATA_W, 8, port and bus data width
- ADDR_W, 8, bus address width
- BASE_ADDR, 8'hE0, window base; must be 32-aligned, window is BASE_ADDR..BASE_ADDR+31
- PULSE_MASK, 0, bit i = 1 puts port i in pulse mode
- PULSE_LEN, 16, pulse-mode hold time in cycles (>= 1)

Ports:
- clk  in  1  single clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- we  in  1  write strobe, sampled each rising edge
- re  in  1  read strobe, sampled each rising edge
- address  in  ADDR_W  byte address
- data_in  in  DATA_W  write data
- data_out  out  DATA_W  registered readback data
- rd_valid  out  1  one-cycle strobe qualifying data_out
- port_out  out  NUM_PORTS*DATA_W  flat port values; port i = bits [i*DATA_W +: DATA_W]
- port_changed  out  NUM_PORTS  one-cycle strobe per port when its value changed

## Operation
- Offset = address - BASE_ADDR; addresses outside the window are ignored (no write; a read returns 0 with rd_valid=1).
- Offset bits [4:3] select the op, bits [2:0] select port index i:
  - 0x00-0x07: overwrite, port <= data_in
  - 0x08-0x0F: set, port <= port | data_in
  - 0x10-0x17: clear, port <= port & ~data_in
  - 0x18-0x1F: toggle, port <= port ^ data_in
- i >= NUM_PORTS: the write is ignored and a read returns 0.
- Reads at any op offset return port i.
- port_changed[i] = 1 for exactly the cycle in which the new value first appears, only if the new value differs from the old one. A write that leaves the value unchanged gives no strobe.
- Pulse-mode port, per-port counter cnt_i of width clog2(PULSE_LEN+1):
  - A write leaving a nonzero value loads cnt_i = PULSE_LEN.
  - A write leaving zero sets cnt_i = 0.
  - While cnt_i > 0 it decrements each cycle.
  - On the 1 -> 0 transition the port clears to 0, and port_changed pulses if the port was nonzero.
  - A write in the same cycle as expiry wins: the new value is applied and the counter is reloaded.
  - A write during an active pulse restarts the full PULSE_LEN.
- Static ports (mask bit 0) hold their value indefinitely.
- Reset: all ports, counters and data_out go to 0; rd_valid=0; port_changed=0. Reset mid-pulse cancels the pulse with no port_changed strobe.

## Timing
- Write sampled at edge k: the new port_out and port_changed are visible after edge k (one-cycle latency). port_changed deasserts after edge k+1.
- Read sampled at edge k: data_out and rd_valid are valid after edge k and last one cycle. data_out holds its last value when rd_valid=0.
- we and re to the same port at the same edge: the read returns the pre-write value.
- Pulse: nonzero write at edge k keeps the port nonzero through edge k+PULSE_LEN-1; it reads 0 after edge k+PULSE_LEN.
- Only one write per cycle exists on the bus, so no write/write arbitration is needed.
- Reset dominates we, re and counter activity in the same cycle.

## Test plan
- Reset, then read 0xE0..0xE3 -> data_out=0x00 and rd_valid=1 each cycle; port_out=0 and port_changed=0.
- Write 0xA5 to 0xE1, then set 0x0A at 0xE9, clear 0x81 at 0xF1, toggle 0xFF at 0xF9 -> port 1 steps 0xA5, 0xAF, 0x2E, 0xD1, with port_changed[1] pulsing once per step. Set 0x01 at 0xE9 (no value change) -> no strobe.
- With NUM_PORTS=4, write 0x55 to 0xE5, then read 0xE5 and 0x40 -> no port changes; both reads return 0x00.
- Same-edge we=re at 0xE0 (old value 0x11, write 0x22) -> data_out=0x11; port_out[0] becomes 0x22.
- PULSE_MASK=1, PULSE_LEN=4: write 0x80 to 0xE0 at edge k -> port 0 = 0x80 through edge k+3 and 0 after edge k+4, with port_changed pulsing at both transitions. A rewrite at edge k+2 extends the clear to edge k+6.
- Assert reset for one cycle at k+1 during a pulse -> port 0 = 0 and counter = 0 with no strobe. The port stays 0 after reset releases.
